ex_mem_reg: RTL and testbench
=============================

Name: ex_mem_reg

Overview:
EX/MEM pipeline register, directly downstream of the ID/EX register and the execute stage.
- Latches ALU result, store data, destination register and MEM/WB control at the end of EX.
- Owns the data-memory request handshake: holds dREN/dWEN until dhit, then drops them.
- Reports mem_stall to the hazard unit while a request is outstanding.
- Implements sticky halt and bubble insertion (flush).

Parameters:
WORD_W, 32, datapath word width (word_t)
REG_W, 5, register index width (regbits_t)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
enable  in  1  hazard unit: advance stage
flush  in  1  hazard unit: load bubble on advance
dhit  in  1  data memory hit/ack from cache/memory control
valid_EX  in  1  EX holds a real instruction
aluout_EX  in  WORD_W  ALU result / memory address
rdat2_EX  in  WORD_W  store data (forwarded)
npc_EX  in  WORD_W  PC+4 for JAL link
lui_EX  in  WORD_W  {imm16,16'b0}
wsel_EX  in  REG_W  destination register
WEN_EX  in  1  register-file write enable
dREN_EX  in  1  load
dWEN_EX  in  1  store
halt_EX  in  1  HALT instruction
wdat_sel_EX  in  2  reg_wdat_mux_selection
valid_EX_MEM, aluout_EX_MEM, rdat2_EX_MEM, npc_EX_MEM, lui_EX_MEM, wsel_EX_MEM, WEN_EX_MEM, halt_EX_MEM, wdat_sel_EX_MEM  out  (matching widths)  registered copies
dmemREN  out  1  data read request
dmemWEN  out  1  data write request
dmemaddr  out  WORD_W  = aluout_EX_MEM
dmemstore  out  WORD_W  = rdat2_EX_MEM
mem_stall  out  1  request outstanding and no dhit this cycle

Behaviour:
- All state updates on posedge CLK. RST is sampled synchronously, and only RST has priority over everything.
- Reset values:
  - All data outputs are 0; valid, WEN, halt, dmemREN and dmemWEN are 0.
  - wdat_sel = SEL_ALU.
  - State = MEM_IDLE.
- Memory FSM (mem_state_t):
  - MEM_IDLE: no outstanding request. Go to MEM_WAIT on a load of a valid entry with dREN_EX|dWEN_EX.
  - MEM_WAIT: dmemREN/dmemWEN = latched dREN/dWEN. On dhit, go to MEM_DONE and clear the latched dREN/dWEN next edge.
  - MEM_DONE: the request has been served and is held until the stage advances. A new load re-enters MEM_WAIT or MEM_IDLE per the new entry.
- mem_stall = (state==MEM_WAIT) & ~dhit, combinational. dhit in the same cycle releases the stall immediately.
- Advance condition: adv = enable & ~mem_stall & ~frozen.
- When adv is 1:
  - flush=1: load a bubble. valid, WEN, dREN, dWEN and halt are 0; data fields are don't-care and are driven 0.
  - flush=0: load all *_EX inputs. Control bits are qualified by valid_EX.
- When adv is 0: hold all registers, including during mem_stall. enable and flush are ignored while mem_stall=1.
- Sticky halt:
  - Once halt_EX_MEM=1 (loaded with valid=1), frozen=1.
  - While frozen, all registers hold until RST, and dmemREN/dmemWEN are 0.
- An entry with both dREN_EX and dWEN_EX set is illegal. The block asserts in simulation; dWEN takes priority in hardware.
- A load of a memory entry in the same cycle as dhit for the old entry is legal: the old entry completes and the new entry starts at MEM_WAIT.
- RST asserted mid-request drops dmemREN/dmemWEN the next edge. No partial state survives.
- Latency: EX values appear on the outputs one cycle after an adv edge. A memory op adds one or more cycles until dhit.

Decomposition:
- cpu_types_pkg gains:
  - reg_wdat_mux_selection {SEL_ALU, SEL_DLOAD, SEL_NPC, SEL_LUI} (2 bits).
  - mem_state_t {MEM_IDLE, MEM_WAIT, MEM_DONE}.
- Ports are bundled in interface ex_mem_reg_if with modports "ex_mem" and "tb".
- No sub-module: the FSM and registers form a single module.

Test Plan:
1. Reset: RST=1 for 2 cycles with random inputs → all outputs 0, wdat_sel=SEL_ALU, mem_stall=0, state MEM_IDLE.
2. ALU op: valid_EX=1, aluout_EX=32'h0000_1234, wsel_EX=5'd8, WEN_EX=1, enable=1 → next cycle aluout_EX_MEM=32'h1234, wsel_EX_MEM=8, WEN_EX_MEM=1, dmemREN=0.
3. Load with 3-cycle miss:
   - Stimulus: dREN_EX=1, aluout_EX=32'h80.
   - Response: dmemREN=1, dmemaddr=32'h80, mem_stall=1 for 3 cycles, and the outputs stay unchanged while enable=1.
   - On dhit: mem_stall=0 the same cycle, and dmemREN=0 the next cycle.
4. Store hit same cycle: dWEN_EX=1, rdat2_EX=32'hDEAD_BEEF, dhit in the first WAIT cycle → dmemstore=32'hDEADBEEF, mem_stall never 1, dmemWEN is high for exactly 1 cycle.
5. Flush vs stall:
   - flush=1 with enable=1 while in MEM_WAIT → ignored; the entry holds until dhit.
   - flush=1 with enable=1 once the stall has cleared → valid/WEN/dREN/dWEN/halt=0.
6. Halt: halt_EX=1, valid_EX=1 → halt_EX_MEM=1 next cycle; the outputs then stay constant for 10 cycles of new inputs with enable=1, and RST clears them.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register widths, write-back mux select and
// the EX/MEM data-memory request states.
package cpu_types_pkg;

  localparam int CPU_WORD_W = 32;
  localparam int CPU_REG_W  = 5;

  typedef logic [CPU_WORD_W-1:0] word_t;
  typedef logic [CPU_REG_W-1:0]  regbits_t;

  typedef enum logic [1:0] {
    SEL_ALU   = 2'd0,
    SEL_DLOAD = 2'd1,
    SEL_NPC   = 2'd2,
    SEL_LUI   = 2'd3
  } reg_wdat_mux_selection;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/ex_mem_reg_if.sv
// Signal bundle for the EX/MEM pipeline register.
interface ex_mem_reg_if #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input logic CLK
);
  logic              RST;
  logic              enable;
  logic              flush;
  logic              dhit;
  logic              valid_EX;
  logic [WORD_W-1:0] aluout_EX;
  logic [WORD_W-1:0] rdat2_EX;
  logic [WORD_W-1:0] npc_EX;
  logic [WORD_W-1:0] lui_EX;
  logic [REG_W-1:0]  wsel_EX;
  logic              WEN_EX;
  logic              dREN_EX;
  logic              dWEN_EX;
  logic              halt_EX;
  logic [1:0]        wdat_sel_EX;
  logic              valid_EX_MEM;
  logic [WORD_W-1:0] aluout_EX_MEM;
  logic [WORD_W-1:0] rdat2_EX_MEM;
  logic [WORD_W-1:0] npc_EX_MEM;
  logic [WORD_W-1:0] lui_EX_MEM;
  logic [REG_W-1:0]  wsel_EX_MEM;
  logic              WEN_EX_MEM;
  logic              halt_EX_MEM;
  logic [1:0]        wdat_sel_EX_MEM;
  logic              dmemREN;
  logic              dmemWEN;
  logic [WORD_W-1:0] dmemaddr;
  logic [WORD_W-1:0] dmemstore;
  logic              mem_stall;

  modport ex_mem (
    input  CLK, RST, enable, flush, dhit, valid_EX, aluout_EX, rdat2_EX, npc_EX,
           lui_EX, wsel_EX, WEN_EX, dREN_EX, dWEN_EX, halt_EX, wdat_sel_EX,
    output valid_EX_MEM, aluout_EX_MEM, rdat2_EX_MEM, npc_EX_MEM, lui_EX_MEM,
           wsel_EX_MEM, WEN_EX_MEM, halt_EX_MEM, wdat_sel_EX_MEM, dmemREN,
           dmemWEN, dmemaddr, dmemstore, mem_stall
  );

  modport tb (
    input  CLK, valid_EX_MEM, aluout_EX_MEM, rdat2_EX_MEM, npc_EX_MEM, lui_EX_MEM,
           wsel_EX_MEM, WEN_EX_MEM, halt_EX_MEM, wdat_sel_EX_MEM, dmemREN,
           dmemWEN, dmemaddr, dmemstore, mem_stall,
    output RST, enable, flush, dhit, valid_EX, aluout_EX, rdat2_EX, npc_EX,
           lui_EX, wsel_EX, WEN_EX, dREN_EX, dWEN_EX, halt_EX, wdat_sel_EX
  );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register. Latches the execute-stage results, drives the
// data-memory request until dhit, stalls the pipe while a request is
// outstanding, freezes after a HALT and inserts bubbles on flush.
module ex_mem_reg
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = CPU_WORD_W,
  parameter int REG_W  = CPU_REG_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              enable,
  input  logic              flush,
  input  logic              dhit,
  input  logic              valid_EX,
  input  logic [WORD_W-1:0] aluout_EX,
  input  logic [WORD_W-1:0] rdat2_EX,
  input  logic [WORD_W-1:0] npc_EX,
  input  logic [WORD_W-1:0] lui_EX,
  input  logic [REG_W-1:0]  wsel_EX,
  input  logic              WEN_EX,
  input  logic              dREN_EX,
  input  logic              dWEN_EX,
  input  logic              halt_EX,
  input  logic [1:0]        wdat_sel_EX,
  output logic              valid_EX_MEM,
  output logic [WORD_W-1:0] aluout_EX_MEM,
  output logic [WORD_W-1:0] rdat2_EX_MEM,
  output logic [WORD_W-1:0] npc_EX_MEM,
  output logic [WORD_W-1:0] lui_EX_MEM,
  output logic [REG_W-1:0]  wsel_EX_MEM,
  output logic              WEN_EX_MEM,
  output logic              halt_EX_MEM,
  output logic [1:0]        wdat_sel_EX_MEM,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_stall
);

  mem_state_t            state, state_n;
  reg_wdat_mux_selection sel_q;
  logic                  dren_q, dwen_q, dren_n, dwen_n;
  logic                  frozen, adv, load_valid, new_dren, new_dwen;

  // Request FSM next state, stall and advance decision.
  always_comb begin
    state_n    = state;
    dren_n     = dren_q;
    dwen_n     = dwen_q;
    frozen     = halt_EX_MEM & valid_EX_MEM;
    mem_stall  = (state == MEM_WAIT) & ~dhit;
    adv        = enable & ~mem_stall & ~frozen;
    load_valid = valid_EX & ~flush;
    // A store wins if both request bits are (illegally) set.
    new_dwen   = load_valid & dWEN_EX;
    new_dren   = load_valid & dREN_EX & ~dWEN_EX;
    if (adv) begin
      dren_n  = new_dren;
      dwen_n  = new_dwen;
      state_n = (new_dren | new_dwen) ? MEM_WAIT : MEM_IDLE;
    end else if ((state == MEM_WAIT) && dhit) begin
      state_n = MEM_DONE;
      dren_n  = 1'b0;
      dwen_n  = 1'b0;
    end
  end

  // Request state and latched request bits.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= MEM_IDLE;
      dren_q <= 1'b0;
      dwen_q <= 1'b0;
    end else begin
      state  <= state_n;
      dren_q <= dren_n;
      dwen_q <= dwen_n;
    end
  end

  // Pipeline register: load on advance (bubble when flushing), else hold.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_EX_MEM  <= 1'b0;
      aluout_EX_MEM <= '0;
      rdat2_EX_MEM  <= '0;
      npc_EX_MEM    <= '0;
      lui_EX_MEM    <= '0;
      wsel_EX_MEM   <= '0;
      WEN_EX_MEM    <= 1'b0;
      halt_EX_MEM   <= 1'b0;
      sel_q         <= SEL_ALU;
    end else if (adv) begin
      if (flush) begin
        valid_EX_MEM  <= 1'b0;
        aluout_EX_MEM <= '0;
        rdat2_EX_MEM  <= '0;
        npc_EX_MEM    <= '0;
        lui_EX_MEM    <= '0;
        wsel_EX_MEM   <= '0;
        WEN_EX_MEM    <= 1'b0;
        halt_EX_MEM   <= 1'b0;
        sel_q         <= SEL_ALU;
      end else begin
        valid_EX_MEM  <= valid_EX;
        aluout_EX_MEM <= aluout_EX;
        rdat2_EX_MEM  <= rdat2_EX;
        npc_EX_MEM    <= npc_EX;
        lui_EX_MEM    <= lui_EX;
        wsel_EX_MEM   <= wsel_EX;
        WEN_EX_MEM    <= WEN_EX & valid_EX;
        halt_EX_MEM   <= halt_EX & valid_EX;
        sel_q         <= reg_wdat_mux_selection'(wdat_sel_EX);
      end
    end
  end

  // Flag entries that request both a load and a store.
  always_ff @(posedge CLK) begin
    if (!RST && adv && load_valid) begin
      assert (!(dREN_EX && dWEN_EX));
    end
  end

  assign wdat_sel_EX_MEM = sel_q;
  assign dmemREN         = (state == MEM_WAIT) & dren_q & ~frozen;
  assign dmemWEN         = (state == MEM_WAIT) & dwen_q & ~frozen;
  assign dmemaddr        = aluout_EX_MEM;
  assign dmemstore       = rdat2_EX_MEM;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg: directed vector table, halt sequence and a randomized
// run against a transaction-level reference model.
module tb_ex_mem_reg;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  ex_mem_reg_if #(.WORD_W(32), .REG_W(5)) bus (.CLK(clk));

  ex_mem_reg #(.WORD_W(32), .REG_W(5)) dut (
    .CLK(bus.CLK), .RST(bus.RST), .enable(bus.enable), .flush(bus.flush),
    .dhit(bus.dhit), .valid_EX(bus.valid_EX), .aluout_EX(bus.aluout_EX),
    .rdat2_EX(bus.rdat2_EX), .npc_EX(bus.npc_EX), .lui_EX(bus.lui_EX),
    .wsel_EX(bus.wsel_EX), .WEN_EX(bus.WEN_EX), .dREN_EX(bus.dREN_EX),
    .dWEN_EX(bus.dWEN_EX), .halt_EX(bus.halt_EX), .wdat_sel_EX(bus.wdat_sel_EX),
    .valid_EX_MEM(bus.valid_EX_MEM), .aluout_EX_MEM(bus.aluout_EX_MEM),
    .rdat2_EX_MEM(bus.rdat2_EX_MEM), .npc_EX_MEM(bus.npc_EX_MEM),
    .lui_EX_MEM(bus.lui_EX_MEM), .wsel_EX_MEM(bus.wsel_EX_MEM),
    .WEN_EX_MEM(bus.WEN_EX_MEM), .halt_EX_MEM(bus.halt_EX_MEM),
    .wdat_sel_EX_MEM(bus.wdat_sel_EX_MEM), .dmemREN(bus.dmemREN),
    .dmemWEN(bus.dmemWEN), .dmemaddr(bus.dmemaddr), .dmemstore(bus.dmemstore),
    .mem_stall(bus.mem_stall)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic en, input logic fl, input logic hit,
                       input logic vld, input logic ren, input logic wen_m, input logic wen,
                       input logic hlt, input logic [31:0] alu, input logic [31:0] r2,
                       input logic [31:0] npc, input logic [31:0] lui, input logic [4:0] ws,
                       input logic [1:0] sel);
    bus.RST = rst; bus.enable = en; bus.flush = fl; bus.dhit = hit;
    bus.valid_EX = vld; bus.dREN_EX = ren; bus.dWEN_EX = wen_m; bus.WEN_EX = wen;
    bus.halt_EX = hlt; bus.aluout_EX = alu; bus.rdat2_EX = r2; bus.npc_EX = npc;
    bus.lui_EX = lui; bus.wsel_EX = ws; bus.wdat_sel_EX = sel;
  endtask

  // Directed vectors: inputs for one cycle, stall expected before the edge,
  // register/request outputs expected after it.
  typedef struct {
    logic en, flush, dhit, valid, dren, dwen, wen;
    logic [31:0] alu, rdat2;
    logic [4:0] wsel;
    logic e_stall, e_valid, e_wen, e_ren, e_wenm;
    logic [31:0] e_alu, e_store;
    logic [4:0] e_wsel;
  } vec_t;
  vec_t vecs [12];

  // Reference model: the entry currently held plus whether its memory
  // request is still waiting for an acknowledge.
  typedef struct packed {
    logic valid, wen, halt, dren, dwen, pending;
    logic [1:0] sel;
    logic [4:0] wsel;
    logic [31:0] alu, rdat2, npc, lui;
  } mdl_t;
  mdl_t m;

  task automatic check_model();
    logic frz;
    frz = m.halt & m.valid;
    chk("rnd_stall", 32'(bus.mem_stall), 32'(m.pending & ~bus.dhit));
    chk("rnd_dmemREN", 32'(bus.dmemREN), 32'(m.pending & m.dren & ~frz));
    chk("rnd_dmemWEN", 32'(bus.dmemWEN), 32'(m.pending & m.dwen & ~frz));
    chk("rnd_valid", 32'(bus.valid_EX_MEM), 32'(m.valid));
    chk("rnd_WEN", 32'(bus.WEN_EX_MEM), 32'(m.wen));
    chk("rnd_halt", 32'(bus.halt_EX_MEM), 32'(m.halt));
    chk("rnd_sel", 32'(bus.wdat_sel_EX_MEM), 32'(m.sel));
    chk("rnd_wsel", 32'(bus.wsel_EX_MEM), 32'(m.wsel));
    chk("rnd_aluout", bus.aluout_EX_MEM, m.alu);
    chk("rnd_rdat2", bus.rdat2_EX_MEM, m.rdat2);
    chk("rnd_npc", bus.npc_EX_MEM, m.npc);
    chk("rnd_lui", bus.lui_EX_MEM, m.lui);
    chk("rnd_dmemaddr", bus.dmemaddr, m.alu);
    chk("rnd_dmemstore", bus.dmemstore, m.rdat2);
  endtask

  task automatic model_edge();
    logic frz, stall, adv, rq_r, rq_w;
    frz   = m.halt & m.valid;
    stall = m.pending & ~bus.dhit;
    adv   = bus.enable & ~stall & ~frz;
    if (bus.RST) m = '0;
    else if (adv) begin
      if (bus.flush) m = '0;
      else begin
        rq_w    = bus.valid_EX & bus.dWEN_EX;
        rq_r    = bus.valid_EX & bus.dREN_EX & ~bus.dWEN_EX;
        m.valid = bus.valid_EX;
        m.wen   = bus.valid_EX & bus.WEN_EX;
        m.halt  = bus.valid_EX & bus.halt_EX;
        m.dren  = rq_r;
        m.dwen  = rq_w;
        m.pending = rq_r | rq_w;
        m.sel   = bus.wdat_sel_EX;
        m.wsel  = bus.wsel_EX;
        m.alu   = bus.aluout_EX;
        m.rdat2 = bus.rdat2_EX;
        m.npc   = bus.npc_EX;
        m.lui   = bus.lui_EX;
      end
    end else if (m.pending && bus.dhit) begin
      m.pending = 1'b0;
      m.dren    = 1'b0;
      m.dwen    = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] hold_alu;
    int kind;
    //               en fl hit vld ren wen wenR alu           rdat2          wsel  stall vld wen ren wenm e_alu         e_store        e_wsel
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,32'h1234,32'h0,5'd8, 1'b0,1'b1,1'b1,1'b0,1'b0,32'h1234,32'h0,5'd8};
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,32'h80,32'h0,5'd9,   1'b0,1'b1,1'b1,1'b1,1'b0,32'h80,32'h0,5'd9};
    vecs[2]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h999,32'h0,5'd3,  1'b1,1'b1,1'b1,1'b1,1'b0,32'h80,32'h0,5'd9};
    vecs[3]  = vecs[2];
    vecs[4]  = vecs[2];
    vecs[5]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,32'h999,32'h0,5'd3,  1'b0,1'b1,1'b0,1'b0,1'b0,32'h999,32'h0,5'd3};
    vecs[6]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,32'h40,32'hDEADBEEF,5'd0, 1'b0,1'b1,1'b0,1'b0,1'b1,32'h40,32'hDEADBEEF,5'd0};
    vecs[7]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,32'h77,32'h0,5'd4,   1'b0,1'b1,1'b0,1'b0,1'b0,32'h40,32'hDEADBEEF,5'd0};
    vecs[8]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,32'h100,32'h11,5'd5, 1'b0,1'b1,1'b1,1'b1,1'b0,32'h100,32'h11,5'd5};
    vecs[9]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,32'h55,32'h0,5'd6,   1'b1,1'b1,1'b1,1'b1,1'b0,32'h100,32'h11,5'd5};
    vecs[10] = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,32'h55,32'h0,5'd6,   1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,5'd0};
    vecs[11] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,32'h5,32'h6,5'd7,    1'b0,1'b1,1'b1,1'b0,1'b0,32'h5,32'h6,5'd7};

    // Reset with random inputs for two cycles
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 1'($urandom), 1'b1, 1'b1, 1'b0, 1'($urandom), 1'($urandom),
            $urandom, $urandom, $urandom, $urandom, 5'($urandom), 2'($urandom));
    end
    @(posedge clk); #1;
    chk("rst_valid", 32'(bus.valid_EX_MEM), 32'd0);
    chk("rst_aluout", bus.aluout_EX_MEM, 32'd0);
    chk("rst_rdat2", bus.rdat2_EX_MEM, 32'd0);
    chk("rst_WEN", 32'(bus.WEN_EX_MEM), 32'd0);
    chk("rst_halt", 32'(bus.halt_EX_MEM), 32'd0);
    chk("rst_sel", 32'(bus.wdat_sel_EX_MEM), 32'd0);
    chk("rst_dmemREN", 32'(bus.dmemREN), 32'd0);
    chk("rst_dmemWEN", 32'(bus.dmemWEN), 32'd0);
    chk("rst_stall", 32'(bus.mem_stall), 32'd0);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(1'b0, vecs[i].en, vecs[i].flush, vecs[i].dhit, vecs[i].valid, vecs[i].dren,
            vecs[i].dwen, vecs[i].wen, 1'b0, vecs[i].alu, vecs[i].rdat2, 32'h0, 32'h0,
            vecs[i].wsel, 2'd0);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(bus.mem_stall), 32'(vecs[i].e_stall));
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), 32'(bus.valid_EX_MEM), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_WEN", i), 32'(bus.WEN_EX_MEM), 32'(vecs[i].e_wen));
      chk($sformatf("v%0d_dmemREN", i), 32'(bus.dmemREN), 32'(vecs[i].e_ren));
      chk($sformatf("v%0d_dmemWEN", i), 32'(bus.dmemWEN), 32'(vecs[i].e_wenm));
      chk($sformatf("v%0d_dmemaddr", i), bus.dmemaddr, vecs[i].e_alu);
      chk($sformatf("v%0d_dmemstore", i), bus.dmemstore, vecs[i].e_store);
      chk($sformatf("v%0d_wsel", i), 32'(bus.wsel_EX_MEM), 32'(vecs[i].e_wsel));
    end

    // Sticky halt: register freezes under new inputs until reset
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
          32'hABC, 32'h1, 32'h2, 32'h3, 5'd9, 2'd2);
    @(posedge clk); #1;
    chk("halt_set", 32'(bus.halt_EX_MEM), 32'd1);
    chk("halt_alu", bus.aluout_EX_MEM, 32'hABC);
    hold_alu = 32'hABC;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      kind = int'($urandom_range(0, 2));
      drive(1'b0, 1'b1, 1'($urandom), 1'($urandom), 1'b1, kind == 1, kind == 2,
            1'($urandom), 1'b0, $urandom, $urandom, $urandom, $urandom,
            5'($urandom), 2'($urandom));
      @(posedge clk); #1;
      chk("frz_alu", bus.aluout_EX_MEM, hold_alu);
      chk("frz_halt", 32'(bus.halt_EX_MEM), 32'd1);
      chk("frz_sel", 32'(bus.wdat_sel_EX_MEM), 32'd2);
      chk("frz_req", 32'({bus.dmemREN, bus.dmemWEN, bus.mem_stall}), 32'd0);
    end
    @(negedge clk);
    bus.RST = 1'b1;
    @(posedge clk); #1;
    chk("halt_rst_halt", 32'(bus.halt_EX_MEM), 32'd0);
    chk("halt_rst_alu", bus.aluout_EX_MEM, 32'd0);
    chk("halt_rst_valid", 32'(bus.valid_EX_MEM), 32'd0);

    // Randomized run against the reference model
    m = '0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      kind = int'($urandom_range(0, 2));
      drive($urandom_range(0, 99) < 3, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, kind == 1, kind == 2,
            1'($urandom), $urandom_range(0, 49) == 0, $urandom, $urandom, $urandom,
            $urandom, 5'($urandom), 2'($urandom));
      #1;
      check_model();
      model_edge();
      @(posedge clk);
    end
    @(negedge clk);
    bus.RST = 1'b0; bus.enable = 1'b0;
    #1;
    check_model();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
